// File: rtl/alu_pkg.sv
// Shared definitions for the br2 multiplier front-end: controller states and defaults.
package alu_pkg;

  localparam int W_DEF        = 64;
  localparam int MAX_WAIT_DEF = 200;

  // The high product word is latched on the edge that leaves WAIT, so no separate
  // read-high state is needed and the controller fits eight states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_LOAD_X,
    S_LOAD_Y,
    S_WAIT,
    S_RD_LO,
    S_DONE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the client that did not finish last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       valid
);

  assign valid = |req;
  assign win   = (&req) ? ~last : req[1];

endmodule

// File: rtl/br2_arb.sv
// Round-robin controller sharing one br2 Booth multiplier between two clients:
// grants, drives the serial bgn/X/Y load, waits for stop, returns both product words.
module br2_arb
  import alu_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic         err,
  output logic         busy,
  output logic         m_bgn,
  output logic [W-1:0] m_inbus,
  input  logic         m_stop,
  input  logic [W-1:0] m_outbus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [W-1:0]   opx_q, opx_d;
  logic [W-1:0]   opy_q, opy_d;
  logic [W-1:0]   res_hi_q, res_hi_d;
  logic [W-1:0]   res_lo_q, res_lo_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           arb_win;
  logic           arb_valid;

  rr_arb2 u_rr (
    .req   ({req1, req0}),
    .last  (last_q),
    .win   (arb_win),
    .valid (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    opx_d    = opx_q;
    opy_d    = opy_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_win;
          opx_d   = arb_win ? a1 : a0;
          opy_d   = arb_win ? b1 : b0;
          err_d   = 1'b0;
          state_d = S_GRANT;
        end
      end
      S_GRANT:  state_d = S_START;
      S_START:  state_d = S_LOAD_X;
      S_LOAD_X: state_d = S_LOAD_Y;
      S_LOAD_Y: state_d = S_WAIT;
      S_WAIT: begin
        // A stop arriving on the final counted cycle still wins over the timeout.
        if (m_stop) begin
          res_hi_d = m_outbus;
          cnt_d    = '0;
          state_d  = S_RD_LO;
        end else if (cnt_q == CW'(MAX_WAIT)) begin
          res_hi_d = '0;
          res_lo_d = '0;
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_LO: begin
        res_lo_d = m_outbus;
        state_d  = S_DONE;
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      opx_q    <= '0;
      opy_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      opx_q    <= opx_d;
      opy_q    <= opy_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode the state register, so reset forces them low without a clock.
  assign busy   = (state_q != S_IDLE);
  assign gnt0   = (state_q == S_GRANT) && !owner_q;
  assign gnt1   = (state_q == S_GRANT) &&  owner_q;
  assign done0  = (state_q == S_DONE)  && !owner_q;
  assign done1  = (state_q == S_DONE)  &&  owner_q;
  assign m_bgn  = (state_q == S_START);
  assign err    = err_q;
  assign res_hi = res_hi_q;
  assign res_lo = res_lo_q;

  always_comb begin
    m_inbus = '0;
    if (state_q == S_LOAD_X) m_inbus = opx_q;
    if (state_q == S_LOAD_Y) m_inbus = opy_q;
  end

endmodule

// File: tb/tb_br2_arb.sv
// Randomised bench for br2_arb: a behavioural br2 model answers the load protocol and a
// scoreboard checks owner order, product words, timeout flag and grant/done latency.
module tb_br2_arb;

  localparam int W        = 64;
  localparam int MAX_WAIT = 200;
  localparam int NEVER    = -1;

  typedef struct {
    int           owner;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    bit           spur;
    bit           first;
    int           req_cyc;
    int           lat;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           err;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         m_stop = 1'b0;
  logic [W-1:0] m_outbus = '0;
  logic         gnt0, gnt1, done0, done1, err, busy, m_bgn;
  logic [W-1:0] res_hi, res_lo, m_inbus;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ref_last = 1;
  bit   abort = 1'b0;
  txn_t txn_q[$];
  txn_t exp_q[$];

  br2_arb #(.W(W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res_hi(res_hi), .res_lo(res_lo), .err(err), .busy(busy),
    .m_bgn(m_bgn), .m_inbus(m_inbus), .m_stop(m_stop), .m_outbus(m_outbus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chki(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] mul_full(logic [W-1:0] x, logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    return sx * sy;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic txn_t mk(int o, logic [W-1:0] a, logic [W-1:0] b, int n, bit sp);
    txn_t t;
    logic [2*W-1:0] p;
    p = mul_full(a, b);
    t.owner = o; t.a = a; t.b = b; t.n = n; t.spur = sp; t.first = 1'b0; t.req_cyc = 0;
    if (n < 0) begin
      t.err = 1'b1; t.hi = '0; t.lo = '0; t.lat = 5 + MAX_WAIT;
    end else begin
      t.err = 1'b0; t.hi = p[2*W-1:W]; t.lo = p[W-1:0]; t.lat = 6 + n;
    end
    return t;
  endfunction

  task automatic push(txn_t t);
    txn_q.push_back(t);
    exp_q.push_back(t);
  endtask

  // Behaviour of the client side while operations are in flight.
  task automatic wait_done(int target, bit drop0);
    int got;
    got = 0;
    for (int k = 0; k < 2 * (MAX_WAIT + 20) && got < target; k++) begin
      @(negedge clk);
      if (gnt0) begin
        {a0, b0} = {$urandom, $urandom, $urandom, $urandom};
        if (drop0) req0 = 1'b0;
      end
      if (gnt1) {a1, b1} = {$urandom, $urandom, $urandom, $urandom};
      if (done0) begin got++; req0 = 1'b0; end
      if (done1) begin got++; req1 = 1'b0; end
    end
    chki("all_done_in_budget", got, target);
    if (got != target) abort = 1'b1;
  endtask

  task automatic run_phase(bit r0, bit r1, logic [W-1:0] x0, logic [W-1:0] y0,
                           logic [W-1:0] x1, logic [W-1:0] y1, int n0, int n1,
                           bit sp0, bit sp1, bit drop0);
    txn_t t0, t1;
    t0 = mk(0, x0, y0, n0, sp0);
    t1 = mk(1, x1, y1, n1, sp1);
    @(negedge clk);
    t0.req_cyc = cyc;
    t1.req_cyc = cyc;
    if (r0 && r1) begin
      if (ref_last == 1) begin
        t0.first = 1'b1; push(t0); push(t1); ref_last = 1;
      end else begin
        t1.first = 1'b1; push(t1); push(t0); ref_last = 0;
      end
    end else if (r0) begin
      t0.first = 1'b1; push(t0); ref_last = 0;
    end else begin
      t1.first = 1'b1; push(t1); ref_last = 1;
    end
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    req0 = r0; req1 = r1;
    wait_done(int'(r0) + int'(r1), drop0);
  endtask

  // Behavioural br2: bgn, X, Y, then stop with the high word and the low word next cycle.
  initial begin : mult_model
    txn_t         t;
    int           c0;
    bit           act;
    bit           in_load;
    logic [W-1:0] x, y;
    logic [2*W-1:0] p;
    act = 1'b0; c0 = 0; x = '0; y = '0; p = '0;
    forever begin
      @(negedge clk);
      m_stop   = 1'b0;
      m_outbus = rnd64();
      if (!rst_b) begin
        act = 1'b0;
      end else begin
        in_load = act && (cyc == c0 + 1 || cyc == c0 + 2);
        if (!in_load) chk("inbus_zero_outside_load", m_inbus, '0);
        if (m_bgn) begin
          chki("bgn_has_txn", txn_q.size(), txn_q.size() == 0 ? 1 : txn_q.size());
          if (txn_q.size() != 0) begin
            t = txn_q.pop_front();
            act = 1'b1;
            c0 = cyc;
          end else begin
            act = 1'b0;
          end
        end else if (act) begin
          if (cyc == c0 + 1) begin
            chk("inbus_x", m_inbus, t.a);
            x = m_inbus;
            if (t.spur) m_stop = 1'b1;
          end else if (cyc == c0 + 2) begin
            chk("inbus_y", m_inbus, t.b);
            y = m_inbus;
            p = mul_full(x, y);
          end else if (t.n >= 0 && cyc == c0 + 3 + t.n) begin
            m_stop   = 1'b1;
            m_outbus = p[2*W-1:W];
          end else if (t.n >= 0 && cyc == c0 + 4 + t.n) begin
            m_outbus = p[W-1:0];
            act = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    txn_t e;
    int   gnt_cyc;
    int   done_cyc;
    gnt_cyc = 0;
    done_cyc = -100;
    forever begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chki("gnt_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("gnt_owner", W'({gnt1, gnt0}), (e.owner == 1) ? W'(2) : W'(1));
          if (e.first) chki("gnt_after_req", cyc - e.req_cyc, 1);
          else         chki("gnt_after_done", cyc - done_cyc, 2);
        end
        gnt_cyc = cyc;
      end
      if (done0 || done1) begin
        chki("done_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("done_owner", W'({done1, done0}), (e.owner == 1) ? W'(2) : W'(1));
          chk("res_hi", res_hi, e.hi);
          chk("res_lo", res_lo, e.lo);
          chk("err", W'(err), W'(e.err));
          chki("done_latency", cyc - gnt_cyc, e.lat);
          $display("txn owner=%0d a=%h b=%h hi=%h lo=%h err=%0b lat=%0d",
                   e.owner, e.a, e.b, res_hi, res_lo, err, cyc - gnt_cyc);
        end
        done_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    txn_t t0, t1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", W'({gnt0, gnt1, done0, done1, err, busy, m_bgn}), '0);
    chk("reset_inbus", m_inbus, '0);
    chk("reset_res", res_hi | res_lo, '0);
    rst_b = 1'b1;

    if (!abort) run_phase(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 3, 7, 0, 0, 0);
    if (!abort) run_phase(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 12, 1, 0, 0, 0);
    if (!abort) run_phase(1, 0, 64'd1200, 64'd1000, '0, '0, 64, 0, 0, 0, 0);
    if (!abort) run_phase(0, 1, '0, '0, -64'sd3, 64'sd5, 0, 10, 0, 0, 0);
    if (!abort) run_phase(1, 0, rnd64(), rnd64(), '0, '0, NEVER, 0, 0, 0, 0);
    if (!abort) run_phase(1, 0, rnd64(), rnd64(), '0, '0, 4, 0, 0, 0, 0);
    if (!abort) run_phase(0, 1, '0, '0, rnd64(), rnd64(), 0, 5, 0, 1, 0);
    if (!abort) run_phase(1, 0, rnd64(), rnd64(), '0, '0, 0, 0, 0, 0, 0);
    if (!abort) run_phase(1, 0, rnd64(), rnd64(), '0, '0, MAX_WAIT, 0, 0, 0, 0);
    if (!abort) run_phase(1, 0, rnd64(), rnd64(), '0, '0, 12, 0, 1, 0, 1);

    // Reset while client 0 sits in WAIT with client 1 pending behind it.
    if (!abort) begin
      t0 = mk(0, rnd64(), rnd64(), 150, 0);
      t0.first = 1'b1;
      @(negedge clk);
      t0.req_cyc = cyc;
      push(t0);
      a0 = t0.a; b0 = t0.b; req0 = 1'b1;
      for (int k = 0; k < 20 && req0; k++) begin
        @(negedge clk);
        if (gnt0) req0 = 1'b0;
      end
      repeat (8) @(negedge clk);
      t1 = mk(1, rnd64(), rnd64(), $urandom_range(0, 20), 0);
      a1 = t1.a; b1 = t1.b; req1 = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      chk("async_reset_ctrl", W'({gnt0, gnt1, done0, done1, err, busy, m_bgn}), '0);
      chk("async_reset_inbus", m_inbus, '0);
      chk("async_reset_res", res_hi | res_lo, '0);
      exp_q.delete();
      txn_q.delete();
      ref_last = 1;
      repeat (2) @(negedge clk);
      chk("reset_hold_ctrl", W'({gnt0, gnt1, done0, done1, err, busy, m_bgn}), '0);
      rst_b = 1'b1;
      t1.first = 1'b1;
      t1.req_cyc = cyc;
      push(t1);
      ref_last = 1;
      wait_done(1, 0);
    end

    for (int i = 0; i < 24 && !abort; i++) begin
      int r;
      r = int'($urandom_range(1, 3));
      run_phase(r[0], r[1], rnd64(), rnd64(), rnd64(), rnd64(),
                int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chki("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
